// File: rtl/pci_target_mem_if.sv
// Muxed PCI bus signals seen by the memory target.
// The initiator side drives FRAME#/IRDY#/C/BE#/AD; the target side returns the rest.
interface pci_target_mem_if;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        devsel_n;
  logic        trdy_n;
  logic        stop_n;
  logic        busy;

  modport master (
    output frame_n, irdy_n, cbe_n, ad_in,
    input  ad_out, ad_oe, devsel_n, trdy_n, stop_n, busy
  );

  modport slave (
    input  frame_n, irdy_n, cbe_n, ad_in,
    output ad_out, ad_oe, devsel_n, trdy_n, stop_n, busy
  );
endinterface

// File: rtl/pci_target_mem.sv
// Simplified PCI memory target with fast DEVSEL#, zero-wait-state bursts into a
// word-addressed buffer, and disconnect-with-data at the top of the window.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          ADDR_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pci_target_mem_if.slave  bus
);

  localparam logic [3:0]           CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0]           CMD_MEM_WRITE = 4'b0111;
  localparam logic [ADDR_BITS-1:0] LAST_PTR      = {ADDR_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE, BUSBUSY, WDATA, RTURN, RDATA, BACKOFF, TURNAR
  } state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [31:0]          r_mem [0:(2**ADDR_BITS)-1];
  logic [31:0]          r_ad_out;
  logic                 r_ad_oe;
  logic                 r_devsel_n;
  logic                 r_trdy_n;
  logic                 r_stop_n;
  logic                 r_busy;

  logic                 w_hit;
  logic [ADDR_BITS-1:0] w_addr_ptr;
  logic                 w_addr_last;
  logic [ADDR_BITS-1:0] w_ptr_next;
  logic                 w_ptr_last;
  logic                 w_xfer;
  logic                 w_wr_en;
  logic                 w_unused;

  assign w_hit       = (bus.ad_in[31:2+ADDR_BITS] == BASE_ADDR[31:2+ADDR_BITS]);
  assign w_addr_ptr  = bus.ad_in[ADDR_BITS+1:2];
  assign w_addr_last = (w_addr_ptr == LAST_PTR);
  assign w_ptr_next  = r_ptr + ADDR_BITS'(1);
  assign w_ptr_last  = (r_ptr == LAST_PTR);
  assign w_xfer      = !bus.irdy_n && !r_trdy_n;
  assign w_wr_en     = (r_state == WDATA) && w_xfer;
  assign w_unused    = ^bus.ad_in[1:0];

  assign bus.ad_out   = r_ad_out;
  assign bus.ad_oe    = r_ad_oe;
  assign bus.devsel_n = r_devsel_n;
  assign bus.trdy_n   = r_trdy_n;
  assign bus.stop_n   = r_stop_n;
  assign bus.busy     = r_busy;

  // Buffer is deliberately not reset; only lanes with an active byte enable change.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.cbe_n[i]) begin
          r_mem[r_ptr][8*i +: 8] <= bus.ad_in[8*i +: 8];
        end
      end
    end
  end

  // Bus protocol FSM; every output is loaded together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_ad_out   <= 32'h0000_0000;
      r_ad_oe    <= 1'b0;
      r_devsel_n <= 1'b1;
      r_trdy_n   <= 1'b1;
      r_stop_n   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.frame_n) begin
            r_ptr  <= w_addr_ptr;
            r_busy <= 1'b1;
            if (w_hit && (bus.cbe_n == CMD_MEM_WRITE)) begin
              r_state    <= WDATA;
              r_devsel_n <= 1'b0;
              r_trdy_n   <= 1'b0;
              r_stop_n   <= !w_addr_last;
            end else if (w_hit && (bus.cbe_n == CMD_MEM_READ)) begin
              r_state    <= RTURN;
              r_devsel_n <= 1'b0;
            end else begin
              r_state <= BUSBUSY;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        BUSBUSY: begin
          if (bus.frame_n && bus.irdy_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= BUSBUSY;
          end
        end
        WDATA, RDATA: begin
          if (w_xfer) begin
            if (w_ptr_last) begin
              // Disconnect with data: never wrap, back off if the initiator wants more.
              r_trdy_n <= 1'b1;
              r_ad_oe  <= 1'b0;
              if (!bus.frame_n) begin
                r_state <= BACKOFF;
              end else begin
                r_state    <= TURNAR;
                r_devsel_n <= 1'b1;
                r_stop_n   <= 1'b1;
              end
            end else if (bus.frame_n) begin
              r_state    <= TURNAR;
              r_devsel_n <= 1'b1;
              r_trdy_n   <= 1'b1;
              r_ad_oe    <= 1'b0;
            end else begin
              r_ptr    <= w_ptr_next;
              r_stop_n <= !(w_ptr_next == LAST_PTR);
              if (r_state == RDATA) begin
                r_ad_out <= r_mem[w_ptr_next];
              end
            end
          end else if (bus.frame_n) begin
            r_state    <= TURNAR;
            r_devsel_n <= 1'b1;
            r_trdy_n   <= 1'b1;
            r_stop_n   <= 1'b1;
            r_ad_oe    <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        RTURN: begin
          r_state  <= RDATA;
          r_trdy_n <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_out <= r_mem[r_ptr];
          r_stop_n <= !w_ptr_last;
        end
        BACKOFF: begin
          if (bus.frame_n) begin
            r_state    <= TURNAR;
            r_devsel_n <= 1'b1;
            r_stop_n   <= 1'b1;
          end else begin
            r_state <= BACKOFF;
          end
        end
        TURNAR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_ad_oe    <= 1'b0;
          r_devsel_n <= 1'b1;
          r_trdy_n   <= 1'b1;
          r_stop_n   <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_mem.sv
// Self-checking bench for pci_target_mem: directed scenarios plus randomized bursts
// checked against a word-array model of the buffer and the bus handshake rules.
module tb_pci_target_mem;
  logic clk;
  logic rst_n;
  pci_target_mem_if bus_if ();

  pci_target_mem #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (!be_n[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus_if.frame_n = 1'b1;
    bus_if.irdy_n  = 1'b1;
    bus_if.ad_in   = $urandom;
    bus_if.cbe_n   = 4'($urandom);
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    bus_if.frame_n = 1'b0;
    bus_if.irdy_n  = 1'b1;
    bus_if.ad_in   = a;
    bus_if.cbe_n   = cmd;
    tick;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 11100",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
    end
    checks++;
    if (bus_if.ad_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_ad_out: got %h exp 00000000", bus_if.ad_out);
    end
  endtask

  task automatic test_fill;
    logic [31:0] d;
    addr_phase(32'h0000_1000 | 32'($urandom_range(0, 3)), 4'b0111);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n} !== {2'b00, (k != 15)}) begin
        errors++;
        $display("FAIL fill_ctl[%0d]: got %b exp %b", k,
                 {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n}, {2'b00, (k != 15)});
      end
      d = $urandom;
      mdl[k] = d;
      bus_if.frame_n = (k == 15);
      bus_if.irdy_n  = 1'b0;
      bus_if.ad_in   = d;
      bus_if.cbe_n   = 4'b0000;
      tick;
    end
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11101) begin
      errors++;
      $display("FAIL fill_turnar: got %b exp 11101",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
    end
    idle_bus;
    tick;
  endtask

  task automatic test_single_write;
    addr_phase(32'h0000_1004, 4'b0111);
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy} !== 4'b0011) begin
      errors++;
      $display("FAIL single_wdata: got %b exp 0011",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy});
    end
    bus_if.frame_n = 1'b1;
    bus_if.irdy_n  = 1'b0;
    bus_if.ad_in   = 32'hDEAD_BEEF;
    bus_if.cbe_n   = 4'b0000;
    mdl[1] = 32'hDEAD_BEEF;
    tick;
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11101) begin
      errors++;
      $display("FAIL single_turnar: got %b exp 11101",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
    end
    idle_bus;
    tick;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy got %b exp 0", bus_if.busy);
    end
    // Byte-enable write over the same word.
    addr_phase(32'h0000_1004, 4'b0111);
    bus_if.frame_n = 1'b1;
    bus_if.irdy_n  = 1'b0;
    bus_if.ad_in   = 32'h1122_3344;
    bus_if.cbe_n   = 4'b1010;
    mdl[1] = merge(mdl[1], 32'h1122_3344, 4'b1010);
    tick;
    idle_bus;
    tick;
  endtask

  task automatic test_read_burst(input int start, input int n);
    addr_phase(32'h0000_1000 + 32'(start * 4), 4'b0110);
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.ad_oe} !== 3'b010) begin
      errors++;
      $display("FAIL rd_rturn@%0d: got %b exp 010", start,
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.ad_oe});
    end
    bus_if.irdy_n = 1'b1;
    tick;
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.ad_out} !==
          {2'b00, (start + k != 15), 1'b1, mdl[start+k]}) begin
        errors++;
        $display("FAIL rd_data[%0d]: got ctl %b data %h exp ctl %b data %h", start + k,
                 {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe}, bus_if.ad_out,
                 {2'b00, (start + k != 15), 1'b1}, mdl[start+k]);
      end
      bus_if.frame_n = (k == n - 1);
      bus_if.irdy_n  = 1'b0;
      tick;
    end
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11101) begin
      errors++;
      $display("FAIL rd_turnar@%0d: got %b exp 11101", start,
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
    end
    idle_bus;
    tick;
  endtask

  task automatic test_irdy_wait;
    logic [31:0] d;
    addr_phase(32'h0000_1010, 4'b0111);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        for (int w = 0; w < 2; w++) begin
          bus_if.frame_n = 1'b0;
          bus_if.irdy_n  = 1'b1;
          bus_if.ad_in   = $urandom;
          bus_if.cbe_n   = 4'b0000;
          tick;
          checks++;
          if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy} !== 4'b0011) begin
            errors++;
            $display("FAIL wait_hold[%0d]: got %b exp 0011", w,
                     {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy});
          end
        end
      end
      d = $urandom;
      mdl[4+k] = d;
      bus_if.frame_n = (k == 2);
      bus_if.irdy_n  = 1'b0;
      bus_if.ad_in   = d;
      bus_if.cbe_n   = 4'b0000;
      tick;
    end
    idle_bus;
    tick;
    test_read_burst(4, 3);
  endtask

  task automatic test_disconnect;
    logic [31:0] d;
    addr_phase(32'h0000_103C, 4'b0111);
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n} !== 3'b000) begin
      errors++;
      $display("FAIL disc_stop: got %b exp 000", {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n});
    end
    d = $urandom;
    mdl[15] = d;
    bus_if.frame_n = 1'b0;
    bus_if.irdy_n  = 1'b0;
    bus_if.ad_in   = d;
    bus_if.cbe_n   = 4'b0000;
    tick;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b01001) begin
        errors++;
        $display("FAIL disc_backoff[%0d]: got %b exp 01001", w,
                 {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
      end
      bus_if.ad_in = $urandom;
      tick;
    end
    bus_if.frame_n = 1'b1;
    bus_if.irdy_n  = 1'b1;
    tick;
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy} !== 4'b1111) begin
      errors++;
      $display("FAIL disc_turnar: got %b exp 1111",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy});
    end
    tick;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL disc_idle: busy got %b exp 0", bus_if.busy);
    end
    test_read_burst(15, 1);
  endtask

  task automatic test_abandon;
    addr_phase(32'h0000_101C, 4'b0111);
    bus_if.frame_n = 1'b1;
    bus_if.irdy_n  = 1'b1;
    bus_if.ad_in   = ~mdl[7];
    bus_if.cbe_n   = 4'b0000;
    tick;
    checks++;
    if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy} !== 4'b1111) begin
      errors++;
      $display("FAIL abandon_turnar: got %b exp 1111",
               {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.busy});
    end
    idle_bus;
    tick;
    test_read_burst(7, 1);
  endtask

  task automatic test_miss;
    logic [31:0] miss_addr [3];
    logic [3:0]  miss_cmd  [3];
    miss_addr[0] = 32'h0000_2000; miss_cmd[0] = 4'b0111;
    miss_addr[1] = 32'h0000_1040; miss_cmd[1] = 4'b0110;
    miss_addr[2] = 32'h0000_1008; miss_cmd[2] = 4'b0011;
    for (int m = 0; m < 3; m++) begin
      addr_phase(miss_addr[m], miss_cmd[m]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11101) begin
          errors++;
          $display("FAIL miss%0d_busy[%0d]: got %b exp 11101", m, k,
                   {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
        end
        bus_if.frame_n = (k == 2);
        bus_if.irdy_n  = 1'b0;
        bus_if.ad_in   = $urandom;
        bus_if.cbe_n   = 4'b0000;
        tick;
      end
      checks++;
      if (bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL miss%0d_irdy_hold: busy got %b exp 1", m, bus_if.busy);
      end
      idle_bus;
      tick;
      checks++;
      if (bus_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL miss%0d_release: busy got %b exp 0", m, bus_if.busy);
      end
    end
    test_read_burst(2, 1);
  endtask

  task automatic test_reset_mid;
    addr_phase(32'h0000_1000, 4'b0110);
    bus_if.irdy_n = 1'b1;
    tick;
    bus_if.irdy_n = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    test_reset;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_read_busy: got %b exp 0", bus_if.busy);
    end
    tick;
    idle_bus;
    rst_n = 1'b1;
    tick;
    // Reset during a write burst must not let the pending data phase land.
    addr_phase(32'h0000_1024, 4'b0111);
    mdl[9] = $urandom;
    bus_if.irdy_n = 1'b0;
    bus_if.ad_in  = mdl[9];
    bus_if.cbe_n  = 4'b0000;
    tick;
    bus_if.ad_in = ~mdl[10];
    #2 rst_n = 1'b0;
    tick;
    idle_bus;
    rst_n = 1'b1;
    tick;
    test_read_burst(9, 2);
  endtask

  task automatic test_random;
    int          start, n, w;
    bit          rd;
    logic [31:0] d;
    logic [3:0]  be;
    for (int t = 0; t < 24; t++) begin
      start = $urandom_range(0, 15);
      n     = $urandom_range(1, 16 - start);
      rd    = 1'($urandom_range(0, 1));
      addr_phase(32'h0000_1000 + 32'(start * 4) + 32'($urandom_range(0, 3)),
                 rd ? 4'b0110 : 4'b0111);
      if (rd) begin
        bus_if.irdy_n = 1'b1;
        tick;
      end
      for (int k = 0; k < n; k++) begin
        w = $urandom_range(0, 2);
        for (int j = 0; j < w; j++) begin
          bus_if.frame_n = 1'b0;
          bus_if.irdy_n  = 1'b1;
          bus_if.ad_in   = $urandom;
          bus_if.cbe_n   = 4'($urandom);
          tick;
        end
        checks++;
        if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n} !== {2'b00, (start + k != 15)} ||
            (rd && (bus_if.ad_out !== mdl[start+k] || bus_if.ad_oe !== 1'b1))) begin
          errors++;
          $display("FAIL rand%0d_%s[%0d]: got ctl %b data %h exp ctl %b data %h", t,
                   rd ? "rd" : "wr", start + k, {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n},
                   bus_if.ad_out, {2'b00, (start + k != 15)}, mdl[start+k]);
        end
        d  = $urandom;
        be = 4'($urandom);
        bus_if.frame_n = (k == n - 1);
        bus_if.irdy_n  = 1'b0;
        bus_if.ad_in   = d;
        bus_if.cbe_n   = be;
        if (!rd) mdl[start+k] = merge(mdl[start+k], d, be);
        tick;
      end
      checks++;
      if ({bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy} !== 5'b11101) begin
        errors++;
        $display("FAIL rand%0d_turnar: got %b exp 11101", t,
                 {bus_if.devsel_n, bus_if.trdy_n, bus_if.stop_n, bus_if.ad_oe, bus_if.busy});
      end
      idle_bus;
      tick;
    end
    test_read_burst(0, 16);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus;
    tick;
    tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_reset;
    test_fill;
    test_single_write;
    test_read_burst(0, 3);
    checks++;
    if (mdl[1] !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL be_model: got %h exp DE22BE44", mdl[1]);
    end
    test_irdy_wait;
    test_disconnect;
    test_abandon;
    test_miss;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_target_mem.md
Name: pci_target_mem

Overview:
- Simplified PCI memory target that sits downstream of the bus mux, consuming the muxed global FRAME#/IRDY#/AD/C/BE# that arbitrated initiators produce.
- Claims memory read/write transactions to a fixed address window with fast DEVSEL#.
- Bursts data into or out of an internal word-addressed register file.
- Uses split ad_in/ad_out plus ad_oe instead of tristates; ad_out/ad_oe are merged by the bus mux.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be aligned to 4*2^ADDR_BITS.
- ADDR_BITS, 4: log2 of buffer depth in 32-bit words (default 16 words, window 0x1000-0x103F).

Ports:
- clk  in  1  bus clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_n  in  1  global FRAME#, active low.
- irdy_n  in  1  global IRDY#, active low.
- cbe_n  in  4  command in address phase; byte enables (active low) in data phases.
- ad_in  in  32  global AD bus as seen by target.
- ad_out  out  32  read data driven to bus.
- ad_oe  out  1  1 = ad_out valid, mux selects target.
- devsel_n  out  1  DEVSEL#, active low.
- trdy_n  out  1  TRDY#, active low.
- stop_n  out  1  STOP#, active low.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; devsel_n=trdy_n=stop_n=1; ad_oe=0; ad_out=0; busy=0. Buffer contents are not reset. Reset mid-burst aborts immediately with no further writes.
- Commands: 4'b0110 = memory read; 4'b0111 = memory write. All others are ignored.
- Hit: ad_in[31:2+ADDR_BITS] == BASE_ADDR[31:2+ADDR_BITS]. ad_in[1:0] is ignored. The word pointer ptr is loaded from ad_in[ADDR_BITS+1:2].
- Data transfer: occurs on a rising edge where irdy_n=0 and trdy_n=0. After each transfer, ptr increments by 1.
- States:
  - IDLE: edge with frame_n=0 is the address phase. Hit+write -> WDATA. Hit+read -> RTURN. Otherwise -> BUSBUSY.
  - BUSBUSY: devsel_n stays 1. Return to IDLE on an edge with frame_n=1 and irdy_n=1.
  - WDATA: devsel_n=0, trdy_n=0, output in the cycle after the address phase (zero wait states). On transfer, write ad_in byte lanes where cbe_n[i]=0 into mem[ptr]; lanes with cbe_n[i]=1 are unchanged.
  - RTURN: one turnaround cycle; devsel_n=0, trdy_n=1, ad_oe=0. -> RDATA.
  - RDATA: devsel_n=0, trdy_n=0, ad_oe=1, ad_out=mem[ptr]. On a transfer, ad_out updates to the next word in the following cycle.
  - Last transfer in WDATA/RDATA (transfer with frame_n=1) -> TURNAR.
  - Disconnect: when ptr = 2^ADDR_BITS-1 in WDATA/RDATA, stop_n=0 is driven with trdy_n=0 (disconnect with data). After that transfer, if frame_n=0 -> BACKOFF, else -> TURNAR. ptr never wraps within a transaction.
  - BACKOFF: devsel_n=0, stop_n=0, trdy_n=1, ad_oe=0. Wait for an edge with frame_n=1; then -> TURNAR.
  - TURNAR: devsel_n=trdy_n=stop_n=1, ad_oe=0 for one cycle. -> IDLE.
- Initiator abandonment: an edge in WDATA/RDATA with frame_n=1 and irdy_n=1 -> TURNAR, with no write.
- Wait states: irdy_n=1 with frame_n=0 holds the current state; no write occurs; ad_out holds.
- Outputs are registered; no combinational input-to-output paths.

Test Plan:
- Single write: addr phase ad_in=0x1004, cbe_n=0111; next cycle frame_n=1, irdy_n=0, ad_in=0xDEADBEEF, cbe_n=0000 -> devsel_n/trdy_n=0 that cycle, mem[1]=0xDEADBEEF, TURNAR cycle with all outputs high, then IDLE.
- Byte-enable write: write 0x11223344 with cbe_n=1010 to 0x1004 (prior 0xDEADBEEF) -> mem[1]=0xDE22BE44.
- Read burst: addr 0x1000, cbe_n=0110, 3 data phases -> devsel_n low one cycle before trdy_n; ad_oe=0 in the RTURN cycle; ad_out returns mem[0], mem[1], mem[2] on consecutive transfers.
- Irdy wait: during a write burst, hold irdy_n=1 for 2 cycles -> no write occurs; state and ptr are unchanged; write resumes when irdy_n=0.
- Disconnect: write burst starting at 0x103C with frame_n held low -> stop_n=0 with trdy_n=0 on the first transfer; mem[15] written; BACKOFF until frame_n=1, then TURNAR, then IDLE.
- Miss and reset: addr 0x2000 write -> devsel_n stays 1, busy=1 until bus idle. Separately, rst_n=0 mid-read -> all outputs go inactive immediately; busy=0.
